// File: rtl/vip_featuremap_channel_joiner_if.sv
// Bus bundle for the featuremap channel joiner: per-channel input streams,
// joined output stream, frame control and status.
interface vip_featuremap_channel_joiner_if #(
    parameter int DWIDTH = 32,
    parameter int NCH    = 8
);
    logic [31:0]            num_data;
    logic [NCH-1:0]         ch_mask;
    logic [NCH*DWIDTH-1:0]  in_data;
    logic [NCH-1:0]         in_wrreq;
    logic [NCH-1:0]         in_full;
    logic [NCH*DWIDTH-1:0]  out_data;
    logic                   out_wrreq;
    logic                   out_full;
    logic                   frame_done;
    logic [31:0]            word_count;
    logic [NCH-1:0]         overflow_err;

    modport slave (
        input  num_data, ch_mask, in_data, in_wrreq, out_full,
        output in_full, out_data, out_wrreq, frame_done, word_count, overflow_err
    );

    modport master (
        output num_data, ch_mask, in_data, in_wrreq, out_full,
        input  in_full, out_data, out_wrreq, frame_done, word_count, overflow_err
    );
endinterface

// File: rtl/vip_featuremap_channel_joiner.sv
// Buffers NCH per-filter streams in per-channel FIFOs and emits one channel-aligned
// joined word whenever every enabled channel holds data; counts words per frame.
module vip_featuremap_channel_joiner #(
    parameter  int DWIDTH = 32,
    parameter  int NCH    = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    vip_featuremap_channel_joiner_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [31:0]            r_num;
    logic [NCH-1:0]         r_mask;
    logic [DWIDTH-1:0]      r_mem   [NCH][DEPTH];
    logic [AW-1:0]          r_wptr  [NCH];
    logic [AW-1:0]          r_rptr  [NCH];
    logic [AW:0]            r_count [NCH];
    logic [AW:0]            w_count_nxt [NCH];
    logic [NCH-1:0]         r_full;
    logic [NCH-1:0]         r_ovf;
    logic [NCH-1:0]         w_wr_acc;
    logic [NCH-1:0]         w_pop;
    logic [NCH-1:0]         w_nonempty;
    logic                   w_fire;
    logic                   w_last;
    logic [NCH*DWIDTH-1:0]  w_join;
    logic [NCH*DWIDTH-1:0]  r_out_data;
    logic                   r_out_wrreq;
    logic                   r_frame_done;
    logic [31:0]            r_word_count;

    // Per-channel accept/pop decisions, join gather and next occupancy
    always_comb begin
        w_wr_acc   = {NCH{1'b0}};
        w_nonempty = {NCH{1'b0}};
        w_join     = {(NCH*DWIDTH){1'b0}};
        for (int k = 0; k < NCH; k++) begin
            w_wr_acc[k]   = bus.in_wrreq[k] & ~r_full[k];
            // Occupancy before this edge: a same-cycle write to an empty FIFO cannot join
            w_nonempty[k] = (r_count[k] != {(AW+1){1'b0}});
            if (r_mask[k]) begin
                w_join[k*DWIDTH +: DWIDTH] = r_mem[k][r_rptr[k]];
            end else begin
                w_join[k*DWIDTH +: DWIDTH] = {DWIDTH{1'b0}};
            end
        end
        w_fire = (r_state == ST_RUN) && ((w_nonempty | ~r_mask) == {NCH{1'b1}}) && !bus.out_full;
        w_last = (r_word_count == (r_num - 32'd1));
        if (w_fire) begin
            w_pop = r_mask;
        end else begin
            w_pop = {NCH{1'b0}};
        end
        for (int k = 0; k < NCH; k++) begin
            case ({w_wr_acc[k], w_pop[k]})
                2'b10:   w_count_nxt[k] = r_count[k] + (AW+1)'(1);
                2'b01:   w_count_nxt[k] = r_count[k] - (AW+1)'(1);
                default: w_count_nxt[k] = r_count[k];
            endcase
        end
    end

    // Frame sequencing
    always_comb begin
        case (r_state)
            ST_IDLE: begin
                if (bus.num_data != 32'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_fire && w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clock) begin
        for (int k = 0; k < NCH; k++) begin
            if (w_wr_acc[k]) begin
                r_mem[k][r_wptr[k]] <= bus.in_data[k*DWIDTH +: DWIDTH];
            end
        end
    end

    // FIFO pointers, occupancy, full and sticky overflow flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NCH; k++) begin
                r_wptr[k]  <= {AW{1'b0}};
                r_rptr[k]  <= {AW{1'b0}};
                r_count[k] <= {(AW+1){1'b0}};
            end
            r_full <= {NCH{1'b0}};
            r_ovf  <= {NCH{1'b0}};
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (w_wr_acc[k]) begin
                    r_wptr[k] <= r_wptr[k] + AW'(1);
                end
                if (w_pop[k]) begin
                    r_rptr[k] <= r_rptr[k] + AW'(1);
                end
                r_count[k] <= w_count_nxt[k];
                r_full[k]  <= (w_count_nxt[k] == (AW+1)'(DEPTH));
                r_ovf[k]   <= r_ovf[k] | (bus.in_wrreq[k] & r_full[k]);
            end
        end
    end

    // Frame state, latched frame parameters and registered output stream
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_num        <= 32'd0;
            r_mask       <= {NCH{1'b0}};
            r_word_count <= 32'd0;
            r_out_data   <= {(NCH*DWIDTH){1'b0}};
            r_out_wrreq  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_out_wrreq  <= w_fire;
            r_frame_done <= (w_state_nxt == ST_DONE);
            if (w_fire) begin
                r_out_data <= w_join;
            end else begin
                r_out_data <= r_out_data;
            end
            if ((r_state == ST_IDLE) && (bus.num_data != 32'd0)) begin
                r_num        <= bus.num_data;
                r_mask       <= (bus.ch_mask == {NCH{1'b0}}) ? {NCH{1'b1}} : bus.ch_mask;
                r_word_count <= 32'd0;
            end else if (w_fire) begin
                r_word_count <= r_word_count + 32'd1;
            end else begin
                r_word_count <= r_word_count;
            end
        end
    end

    assign bus.in_full      = r_full;
    assign bus.out_data     = r_out_data;
    assign bus.out_wrreq    = r_out_wrreq;
    assign bus.frame_done   = r_frame_done;
    assign bus.word_count   = r_word_count;
    assign bus.overflow_err = r_ovf;

endmodule

// File: tb/tb_vip_featuremap_channel_joiner.sv
// Randomized bench for the channel joiner: per-channel queue model, scoreboard on
// every joined word, frame completion, latency, masking, overflow and reset checks.
module tb_vip_featuremap_channel_joiner;

    localparam int DW    = 32;
    localparam int NCH   = 8;
    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    vip_featuremap_channel_joiner_if #(.DWIDTH(DW), .NCH(NCH)) bus ();

    vip_featuremap_channel_joiner #(.DWIDTH(DW), .NCH(NCH), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0]  mq [NCH][$];
    logic [NCH-1:0] exp_mask;
    int             exp_num;
    int             frame_words;
    int             done_seen;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: capture driven inputs at the edge, then score outputs and update the model
    task automatic tick();
        logic [NCH-1:0]    wr;
        logic [NCH*DW-1:0] d;
        logic              pf;
        logic [NCH*DW-1:0] ew;
        @(posedge clock);
        wr = bus.in_wrreq;
        d  = bus.in_data;
        pf = bus.out_full;
        #1;
        if (bus.out_wrreq) begin
            ew = '0;
            chk("join_while_full", pf, 1'b0);
            for (int k = 0; k < NCH; k++) begin
                if (exp_mask[k]) begin
                    chk("join_without_data", mq[k].size() != 0, 1'b1);
                    if (mq[k].size() != 0) ew[k*DW +: DW] = mq[k].pop_front();
                end
            end
            chk("out_data", bus.out_data, ew);
            frame_words++;
            chk("word_count", bus.word_count, frame_words);
        end
        if (bus.frame_done) begin
            done_seen++;
            chk("done_words", frame_words, exp_num);
        end
        for (int k = 0; k < NCH; k++) begin
            if (wr[k]) mq[k].push_back(d[k*DW +: DW]);
        end
    endtask

    task automatic start_frame(input int num, input logic [NCH-1:0] mask);
        bus.num_data = num;
        bus.ch_mask  = mask;
        exp_num      = num;
        exp_mask     = (mask == '0) ? '1 : mask;
        frame_words  = 0;
        done_seen    = 0;
        tick();
        bus.num_data = 32'd0;
        bus.ch_mask  = NCH'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int cnt = 0;
        bus.in_wrreq = '0;
        bus.out_full = 1'b0;
        while (done_seen == 0 && cnt < budget) begin
            tick();
            cnt++;
        end
        chk("frame_done_seen", done_seen, 1);
        chk("frame_words", frame_words, exp_num);
        tick();
        tick();
        chk("frame_done_once", done_seen, 1);
    endtask

    task automatic run_random_frame(input int num, input logic [NCH-1:0] mask, input int mode);
        int pushed [NCH];
        int cyc = 0;
        start_frame(num, mask);
        for (int k = 0; k < NCH; k++) pushed[k] = 0;
        while (done_seen == 0 && cyc < 2000) begin
            for (int k = 0; k < NCH; k++) begin
                bus.in_wrreq[k] = 1'b0;
                bus.in_data[k*DW +: DW] = $urandom;
                if (exp_mask[k]) begin
                    if (pushed[k] < num && mq[k].size() < DEPTH && $urandom_range(0, 3) != 0) begin
                        bus.in_wrreq[k] = 1'b1;
                        pushed[k]++;
                    end
                end else if (mq[k].size() < 4 && $urandom_range(0, 7) == 0) begin
                    bus.in_wrreq[k] = 1'b1;
                end
            end
            case (mode)
                0:       bus.out_full = 1'b0;
                1:       bus.out_full = cyc[0];
                default: bus.out_full = 1'($urandom_range(0, 1));
            endcase
            tick();
            cyc++;
        end
        wait_done(50);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        bus.num_data = 32'd0;
        bus.ch_mask  = '0;
        bus.in_data  = '0;
        bus.in_wrreq = '0;
        bus.out_full = 1'b0;
        exp_mask     = '1;
        exp_num      = 0;
        frame_words  = 0;
        done_seen    = 0;
        #12;
        chk("rst_out_wrreq", bus.out_wrreq, 1'b0);
        chk("rst_in_full", bus.in_full, '0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_word_count", bus.word_count, '0);
        chk("rst_overflow", bus.overflow_err, '0);
        chk("rst_frame_done", bus.frame_done, 1'b0);
        reset = 1'b1;

        // Lockstep frame of 4 words, channel k carries n; first word has 2-edge latency
        start_frame(4, '1);
        for (int n = 1; n <= 4; n++) begin
            bus.in_wrreq = '1;
            for (int k = 0; k < NCH; k++) bus.in_data[k*DW +: DW] = n;
            tick();
            if (n == 1) chk("latency_edge1", bus.out_wrreq, 1'b0);
            if (n == 2) chk("latency_edge2", bus.out_wrreq, 1'b1);
        end
        wait_done(20);

        // Channel 0 runs ahead; nothing joins until every channel has data
        start_frame(3, '1);
        bus.in_wrreq = 8'h01;
        for (int n = 0; n < 3; n++) begin
            bus.in_data[0 +: DW] = $urandom;
            tick();
        end
        bus.in_wrreq = '0;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("no_early_join", bus.out_wrreq, 1'b0);
        end
        bus.in_wrreq = 8'hFE;
        for (int n = 0; n < 3; n++) begin
            for (int k = 1; k < NCH; k++) bus.in_data[k*DW +: DW] = $urandom;
            tick();
        end
        wait_done(20);

        // Masked frame: channels 1 and 3 get data that must survive for the next frame
        start_frame(2, 8'b0000_0101);
        bus.in_wrreq = 8'b0000_1111;
        for (int k = 0; k < NCH; k++) bus.in_data[k*DW +: DW] = $urandom;
        tick();
        bus.in_wrreq = 8'b0000_0101;
        for (int k = 0; k < NCH; k++) bus.in_data[k*DW +: DW] = $urandom;
        tick();
        wait_done(20);
        run_random_frame(3, '1, 0);

        // Randomized frames with random masks and downstream backpressure patterns
        for (int f = 0; f < 8; f++) begin
            run_random_frame($urandom_range(1, 12), (f % 3 == 0) ? '0 : NCH'($urandom), f % 3);
        end

        // Asynchronous reset in the middle of an 8-word frame
        begin
            int cyc = 0;
            start_frame(8, '1);
            bus.out_full = 1'b0;
            while (frame_words < 2 && cyc < 100) begin
                bus.in_wrreq = '1;
                for (int k = 0; k < NCH; k++) bus.in_data[k*DW +: DW] = $urandom;
                tick();
                cyc++;
            end
            chk("reset_setup_words", frame_words, 2);
        end
        bus.in_wrreq = '0;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_wrreq", bus.out_wrreq, 1'b0);
        chk("mid_rst_word_count", bus.word_count, '0);
        chk("mid_rst_out_data", bus.out_data, '0);
        chk("mid_rst_in_full", bus.in_full, '0);
        for (int k = 0; k < NCH; k++) mq[k].delete();
        #10;
        reset = 1'b1;
        tick();
        run_random_frame(8, '1, 2);

        // Overflow on channel 3 while idle with downstream full
        bus.out_full = 1'b1;
        bus.in_wrreq = 8'h08;
        for (int i = 1; i <= 17; i++) begin
            bus.in_data[3*DW +: DW] = $urandom;
            tick();
            if (i == 15) chk("full_at_15", bus.in_full, '0);
            if (i == 16) begin
                chk("full_at_16", bus.in_full, 8'h08);
                chk("no_ovf_at_16", bus.overflow_err, '0);
            end
            if (i == 17) begin
                chk("ovf_at_17", bus.overflow_err, 8'h08);
                chk("full_at_17", bus.in_full, 8'h08);
            end
        end
        bus.in_wrreq = '0;
        for (int i = 0; i < 3; i++) tick();
        chk("ovf_sticky", bus.overflow_err, 8'h08);
        #2;
        reset = 1'b0;
        #1;
        chk("ovf_rst_clear", bus.overflow_err, '0);
        chk("full_rst_clear", bus.in_full, '0);
        for (int k = 0; k < NCH; k++) mq[k].delete();
        #10;
        reset = 1'b1;
        bus.out_full = 1'b0;
        tick();
        run_random_frame(5, '1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
